mux4_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 output mux between four packet requesters (channels a=0, b=1, c=2, d=3).
- Holds a grant for the length of a packet and drives the mux select pair {s1,s0} from the winner index.
- Gates the muxed data onto a single downstream channel with a valid/ready handshake.
- Sits in front of the existing 4:1 mux datapath; the mux itself is instantiated inside this block.

---
 rtl/mux4_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin packet arbiter in front of a 4:1 data mux with valid/ready output.
// Optional per-grant beat limit with preemption: define MUX4_RR_BURST_LIMIT_EN.
module mux4_rr_arbiter #(
    parameter int DATA_W    = 1,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [3:0]            last,
    input  logic [4*DATA_W-1:0]   din,
    input  logic                  ready,
    output logic [3:0]            gnt,
    output logic [1:0]            sel,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy,
    output logic                  preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic   [3:0]          gnt_nxt;
    logic   [1:0]          sel_nxt;
    logic   [1:0]          ptr, ptr_nxt;
    logic   [1:0]          win;
    logic                  s1, s0;
    logic                  xfer;
    logic                  force_rel;
    logic   [DATA_W-1:0]   mux_out;

    assign s1   = sel[1];
    assign s0   = sel[0];
    assign xfer = (state == GRANT) && req[sel] && ready;

    // Descending scan so the requester closest to ptr is assigned last and wins.
    always_comb begin
        win = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) win = ptr + 2'(k);
        end
    end

    always_comb begin
        case ({s1, s0})
            2'd0:    mux_out = din[0        +: DATA_W];
            2'd1:    mux_out = din[DATA_W   +: DATA_W];
            2'd2:    mux_out = din[2*DATA_W +: DATA_W];
            default: mux_out = din[3*DATA_W +: DATA_W];
        endcase
    end

`ifdef MUX4_RR_BURST_LIMIT_EN
    localparam int                CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]     CNT_MAX   = CW'(MAX_BURST);
    localparam logic [CW-1:0]     CNT_LIMIT = CW'(MAX_BURST - 1);

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] beat_cnt_nxt;

    assign force_rel = xfer && !last[sel] && (beat_cnt == CNT_LIMIT);

    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (state == IDLE) begin
            beat_cnt_nxt = '0;
        end else if (xfer && beat_cnt != CNT_MAX) begin
            beat_cnt_nxt = beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            beat_cnt <= beat_cnt_nxt;
            preempt  <= force_rel;
        end
    end
`else
    assign force_rel = 1'b0;
    assign preempt   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // sel is only reloaded when a new grant is issued; it keeps its value in IDLE.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                if (|req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << win;
                    sel_nxt   = win;
                end
            end
            GRANT: begin
                if ((xfer && last[sel]) || force_rel) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    ptr_nxt   = sel + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        busy       = (state == GRANT);
        dout_valid = busy && req[sel];
        dout       = busy ? mux_out : '0;
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized and directed bench for mux4_rr_arbiter against a packet-level reference model.
module tb_mux4_rr_arbiter;

    localparam int DW = 4;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [3:0]        last;
    logic [4*DW-1:0]   din;
    logic              ready;
    logic [3:0]        gnt;
    logic [1:0]        sel;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic              busy;
    logic              preempt;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    bit m_pre;
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_beats;
    int ch0_sent;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din), .ready(ready),
        .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid), .busy(busy),
        .preempt(preempt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                                 input logic [4*DW-1:0] d, input logic rdy);
        req   = r;
        last  = l;
        din   = d;
        ready = rdy;
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_pre   = 1'b0;
        m_owner = 0;
        m_sel   = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    // Expected outputs derived from who owns the mux and what the owner presents.
    task automatic compareAll();
        logic [3:0]    eg;
        logic          ev;
        logic [DW-1:0] ed;
        eg = m_busy ? 4'(1 << m_owner) : 4'd0;
        ev = m_busy && req[m_owner];
        ed = m_busy ? din[m_owner*DW +: DW] : '0;
        checkOutput("gnt",        32'(gnt),        32'(eg));
        checkOutput("sel",        32'(sel),        32'(m_sel));
        checkOutput("busy",       32'(busy),       32'(m_busy));
        checkOutput("dout_valid", 32'(dout_valid), 32'(ev));
        checkOutput("dout",       32'(dout),       32'(ed));
        checkOutput("preempt",    32'(preempt),    32'(m_pre));
    endtask

    task automatic stepModel();
        bit beat;
        m_pre = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                if (!m_busy && req[(m_ptr + k) % 4]) begin
                    m_busy  = 1'b1;
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end else begin
            beat = req[m_owner] && ready;
            if (beat) begin
                m_beats++;
                if (m_owner == 0) ch0_sent++;
                if (last[m_owner]) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % 4;
                end
`ifdef MUX4_RR_BURST_LIMIT_EN
                else if (m_beats >= MB) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % 4;
                    m_pre  = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic tick(input logic [3:0] r, input logic [3:0] l,
                        input logic [4*DW-1:0] d, input logic rdy);
        @(negedge clk);
        applyStimulus(r, l, d, rdy);
        #1;
        compareAll();
        @(posedge clk);
        stepModel();
    endtask

    initial begin
        rst_n = 1'b0;
        ch0_sent = 0;
        applyStimulus(4'd0, 4'd0, '0, 1'b0);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_gnt",  32'(gnt),        32'd0);
        checkOutput("rst_sel",  32'(sel),        32'd0);
        checkOutput("rst_busy", 32'(busy),       32'd0);
        checkOutput("rst_val",  32'(dout_valid), 32'd0);
        checkOutput("rst_dout", 32'(dout),       32'd0);
        checkOutput("rst_pre",  32'(preempt),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (10) tick(4'd0, 4'd0, 16'($urandom), 1'b1);

        // Lone requester 2 sends 1,0,1; pointer should then favour channel 3.
        tick(4'b0100, 4'b0000, 16'h0100, 1'b1);
        tick(4'b0100, 4'b0000, 16'h0100, 1'b1);
        tick(4'b0100, 4'b0000, 16'h0000, 1'b1);
        tick(4'b0100, 4'b0100, 16'h0100, 1'b1);
        tick(4'b0000, 4'b0000, 16'h0000, 1'b1);
        tick(4'b1001, 4'b1001, 16'h0000, 1'b1);
        #1;
        checkOutput("ptr_after_ch2", 32'(gnt), 32'h8);
        tick(4'b1001, 4'b1001, 16'h0000, 1'b1);

        repeat (10) tick(4'b1111, 4'b1111, 16'($urandom), 1'b1);
        tick(4'd0, 4'd0, '0, 1'b1);

        // Backpressure then requester gap on channel 1 with stable data.
        repeat (5) tick(4'b0010, 4'b0000, 16'h5A30, 1'b0);
        tick(4'b0010, 4'b0000, 16'h5A30, 1'b1);
        repeat (2) tick(4'b0000, 4'b0000, 16'h5A30, 1'b1);
        tick(4'b0010, 4'b0010, 16'h5A30, 1'b1);
        tick(4'd0, 4'd0, '0, 1'b1);

        // Asynchronous reset in the middle of channel 3's packet.
        repeat (3) tick(4'b1000, 4'b0000, 16'hC000, 1'b1);
        @(negedge clk);
        applyStimulus(4'b1000, 4'b0000, 16'hC000, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_gnt",  32'(gnt),        32'd0);
        checkOutput("arst_val",  32'(dout_valid), 32'd0);
        checkOutput("arst_busy", 32'(busy),       32'd0);
        checkOutput("arst_dout", 32'(dout),       32'd0);
        modelReset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        stepModel();
        tick(4'b1000, 4'b1000, 16'hF000, 1'b1);
        repeat (2) tick(4'd0, 4'd0, '0, 1'b1);

        // Six-beat packet on channel 0 competing with channel 1.
        ch0_sent = 0;
        repeat (16) tick({2'b00, 1'b1, ch0_sent < 6}, {2'b00, 1'b1, ch0_sent == 5},
                         16'($urandom), 1'b1);
        checkOutput("ch0_beats", 32'(ch0_sent), 32'd6);
        repeat (2) tick(4'd0, 4'd0, '0, 1'b1);

        repeat (600) tick(4'($urandom), 4'($urandom & $urandom), 16'($urandom),
                          1'($urandom_range(0, 3) != 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
